// File: rtl/dff_edge_counter.sv
// Debounces a synchronous flop output, emits rise/fall pulses and counts selected edges.
// Latency: DEB_CYC enabled posedges from a stable new level to pulse/level/count; no backpressure.
module dff_edge_counter #(
    parameter int CNT_W   = 8,
    parameter int DEB_CYC = 2,
    parameter int SAT_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q_in,
    input  logic             clr,
    input  logic [1:0]       edge_sel,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             ovf
);

    localparam int               DEB_W   = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_TGT = DEB_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_CHK_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_CHK_L = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0] deb_inc;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             cnt_evt;

    assign deb_inc = deb_cnt_q + DEB_W'(1);

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (en) begin
            case (state_q)
                ST_LOW: begin
                    if (q_in) begin
                        if (DEB_CYC == 1) begin
                            state_d = ST_HIGH;
                            rise_d  = 1'b1;
                        end else begin
                            state_d   = ST_CHK_H;
                            deb_cnt_d = DEB_W'(1);
                        end
                    end
                end
                ST_CHK_H: begin
                    if (!q_in) begin
                        state_d   = ST_LOW;
                        deb_cnt_d = '0;
                    end else if (deb_inc == DEB_TGT) begin
                        state_d   = ST_HIGH;
                        deb_cnt_d = '0;
                        rise_d    = 1'b1;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end
                ST_HIGH: begin
                    if (!q_in) begin
                        if (DEB_CYC == 1) begin
                            state_d = ST_LOW;
                            fall_d  = 1'b1;
                        end else begin
                            state_d   = ST_CHK_L;
                            deb_cnt_d = DEB_W'(1);
                        end
                    end
                end
                default: begin
                    if (q_in) begin
                        state_d   = ST_HIGH;
                        deb_cnt_d = '0;
                    end else if (deb_inc == DEB_TGT) begin
                        state_d   = ST_LOW;
                        deb_cnt_d = '0;
                        fall_d    = 1'b1;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end
            endcase
        end
        level_d = (state_d == ST_HIGH) || (state_d == ST_CHK_L);
    end

    // Counting keys off the pulse being generated this cycle so count and pulse land together.
    always_comb begin
        cnt_evt = (rise_d && (edge_sel == 2'b00 || edge_sel == 2'b10)) ||
                  (fall_d && (edge_sel == 2'b01 || edge_sel == 2'b10));
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (cnt_evt) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end else if (SAT_EN == 0) begin
                count_d = '0;
                ovf_d   = 1'b1;
            end
        end
        sat_d = (SAT_EN != 0) && (count_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_LOW;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign count      = count_q;
    assign sat        = sat_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_dff_edge_counter.sv
// Directed bench: default instance plus 3-bit saturating and wrapping instances on shared inputs.
module tb_dff_edge_counter;

    logic       clk = 1'b0;
    logic       rst, en, q_in, clr;
    logic [1:0] edge_sel;

    logic       level, rise_pulse, fall_pulse, sat, ovf;
    logic [7:0] count;
    logic       s_level, s_rise, s_fall, s_sat, s_ovf;
    logic [2:0] s_count;
    logic       w_level, w_rise, w_fall, w_sat, w_ovf;
    logic [2:0] w_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dff_edge_counter #(.CNT_W(8), .DEB_CYC(2), .SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr(clr), .edge_sel(edge_sel),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .count(count), .sat(sat), .ovf(ovf));

    dff_edge_counter #(.CNT_W(3), .DEB_CYC(2), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr(clr), .edge_sel(edge_sel),
        .level(s_level), .rise_pulse(s_rise), .fall_pulse(s_fall),
        .count(s_count), .sat(s_sat), .ovf(s_ovf));

    dff_edge_counter #(.CNT_W(3), .DEB_CYC(2), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr(clr), .edge_sel(edge_sel),
        .level(w_level), .rise_pulse(w_rise), .fall_pulse(w_fall),
        .count(w_count), .sat(w_sat), .ovf(w_ovf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Advance one posedge; outputs are then sampled 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; q_in = 1'b1; clr = 1'b0; edge_sel = 2'b00;

        // 1: reset holds everything low even with q_in=1
        step(4);
        chk("rst_level", level, 0);
        chk("rst_count", count, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_sat", s_sat, 0);
        chk("rst_ovf", w_ovf, 0);
        rst = 1'b1;
        step(1);
        chk("rel_p1_rise", rise_pulse, 0);
        chk("rel_p1_level", level, 0);
        step(1);
        chk("rel_p2_rise", rise_pulse, 1);
        chk("rel_p2_level", level, 1);
        chk("rel_p2_count", count, 1);
        step(1);
        chk("rel_p3_rise", rise_pulse, 0);

        q_in = 1'b0;
        step(1);
        chk("fall_p1_level", level, 1);
        chk("fall_p1_fall", fall_pulse, 0);
        step(1);
        chk("fall_p2_fall", fall_pulse, 1);
        chk("fall_p2_level", level, 0);
        chk("fall_sel00_count", count, 1);

        // 2: level held 5 cycles gives exactly one rise at the 2nd posedge
        q_in = 1'b1;
        step(1);
        chk("t2_p1_rise", rise_pulse, 0);
        chk("t2_p1_fall", fall_pulse, 0);
        step(1);
        chk("t2_p2_rise", rise_pulse, 1);
        chk("t2_p2_count", count, 2);
        for (int i = 3; i <= 5; i++) begin
            step(1);
            chk("t2_hold_rise", rise_pulse, 0);
            chk("t2_hold_level", level, 1);
            chk("t2_hold_count", count, 2);
        end
        q_in = 1'b0;
        step(2);
        chk("t2_fall", fall_pulse, 1);

        // 3: one-cycle glitch is rejected and the FSM returns to LOW
        q_in = 1'b1;
        step(1);
        q_in = 1'b0;
        step(1);
        chk("t3_rise", rise_pulse, 0);
        chk("t3_level", level, 0);
        chk("t3_count", count, 2);
        q_in = 1'b1;
        step(1);
        chk("t3_restart_rise", rise_pulse, 0);
        q_in = 1'b0;
        step(1);
        chk("t3_end_level", level, 0);

        // 4: en=0 freezes the debounce and suppresses pulses
        q_in = 1'b1;
        step(1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t4_frozen_rise", rise_pulse, 0);
            chk("t4_frozen_level", level, 0);
        end
        en = 1'b1;
        step(1);
        chk("t4_rise", rise_pulse, 1);
        chk("t4_count", count, 3);
        en = 1'b0;
        q_in = 1'b0;
        step(1);
        chk("t4_en0_clear", rise_pulse, 0);
        step(1);
        chk("t4_en0_hold_level", level, 1);
        en = 1'b1;

        // edge_sel variants
        edge_sel = 2'b01;
        step(2);
        chk("sel01_fall", fall_pulse, 1);
        chk("sel01_count", count, 4);
        edge_sel = 2'b10;
        q_in = 1'b1;
        step(2);
        chk("sel10_rise_count", count, 5);
        q_in = 1'b0;
        step(2);
        chk("sel10_fall_count", count, 6);
        edge_sel = 2'b11;
        q_in = 1'b1;
        step(2);
        chk("sel11_rise", rise_pulse, 1);
        chk("sel11_count", count, 6);
        q_in = 1'b0;
        step(1);
        edge_sel = 2'b01;
        step(1);
        chk("selchg_fall", fall_pulse, 1);
        chk("selchg_count", count, 7);

        // clr works while en=0
        en = 1'b0; clr = 1'b1;
        step(1);
        chk("clr_en0_count", count, 0);
        chk("clr_en0_scount", s_count, 0);
        chk("clr_en0_wcount", w_count, 0);
        en = 1'b1; clr = 1'b0; edge_sel = 2'b00;

        // 5: 3-bit saturate vs wrap over 9 rises
        for (int i = 1; i <= 9; i++) begin
            q_in = 1'b1;
            step(2);
            chk("t5_sat_count", s_count, (i > 7) ? 7 : i);
            chk("t5_sat_flag", s_sat, (i >= 7) ? 1 : 0);
            chk("t5_sat_ovf", s_ovf, 0);
            chk("t5_wrap_count", w_count, i % 8);
            chk("t5_wrap_ovf", w_ovf, (i >= 8) ? 1 : 0);
            chk("t5_wrap_sat", w_sat, 0);
            chk("t5_main_count", count, i);
            q_in = 1'b0;
            step(2);
        end

        // 6: clr on the rise posedge wins over the count event
        q_in = 1'b1;
        step(1);
        clr = 1'b1;
        step(1);
        chk("t6_clr_rise", rise_pulse, 1);
        chk("t6_clr_count", count, 0);
        chk("t6_clr_wovf", w_ovf, 0);
        chk("t6_clr_ssat", s_sat, 0);
        chk("t6_clr_level", level, 1);
        clr = 1'b0;
        q_in = 1'b0;
        step(2);
        chk("t6_fall", fall_pulse, 1);
        q_in = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_rise", rise_pulse, 0);
        rst = 1'b1;
        step(1);
        chk("t6_post_rst_p1", rise_pulse, 0);
        step(1);
        chk("t6_post_rst_p2", rise_pulse, 1);
        chk("t6_post_rst_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
